// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: 16-byte queue filled from a 64-bit instruction memory,
// presents one variable-length instruction at a time. Optional INSTR_PREFETCH_STATS_EN adds counters.
module instr_prefetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [63:0] redirect_addr,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [63:0] mem_data,
   input  logic        mem_err,
   output logic        ins_valid,
   output logic [79:0] ins_bytes,
   output logic [3:0]  ins_len,
   output logic [63:0] ins_addr,
   output logic        ins_err,
   input  logic        ins_take
`ifdef INSTR_PREFETCH_STATS_EN
   ,
   output logic [63:0] insn_count,
   output logic [63:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

   state_t         state;
   logic [127:0]   q_reg;
   logic [4:0]     count_reg;
   logic [63:0]    head_pc;
   logic [63:0]    fetch_addr;
   logic [2:0]     offset_reg;

   logic [3:0]     head_len;
   logic           normal_valid;
   logic           err_present;
   logic           take_fire;
   logic           ack_fire;
   logic           enq;
   logic [3:0]     load_len;
   logic [4:0]     deq;
   logic [4:0]     c1;
   logic [63:0]    word;
   logic [127:0]   q_next;
   logic [4:0]     count_next;

   function automatic logic [3:0] icode_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       icode_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: icode_len = 4'd2;
         4'h7, 4'h8:             icode_len = 4'd9;
         4'h3, 4'h4, 4'h5:       icode_len = 4'd10;
         default:                icode_len = 4'd1;
      endcase
   endfunction

   assign head_len     = icode_len(q_reg[7:4]);
   assign normal_valid = (count_reg >= {1'b0, head_len});
   // A fetch error only surfaces once every complete instruction ahead of it is gone.
   assign err_present  = (state == ERR) && !normal_valid;
   assign ins_valid    = normal_valid || err_present;
   assign ins_err      = err_present;
   assign ins_len      = err_present ? 4'd1 : (normal_valid ? head_len : 4'd0);
   assign ins_addr     = head_pc;

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_bytes
         assign ins_bytes[8*gi +: 8] = (normal_valid && (4'(gi) < head_len)) ? q_reg[8*gi +: 8] : 8'h00;
      end
   endgenerate

   assign load_len = 4'd8 - {1'b0, offset_reg};
   assign mem_req  = (state == DRAIN) ||
                     ((state == RUN) && (({1'b0, count_reg} + {2'b00, load_len}) <= 6'd16));
   assign mem_addr = fetch_addr;

   assign take_fire = ins_take && normal_valid && !redirect;
   assign ack_fire  = mem_ack && mem_req;
   assign enq       = ack_fire && !mem_err && (state == RUN);

   // Dequeue first, then append the new word right behind the surviving bytes.
   always_comb begin
      deq        = take_fire ? {1'b0, head_len} : 5'd0;
      c1         = count_reg - deq;
      word       = mem_data >> {offset_reg, 3'b000};
      q_next     = q_reg >> {deq, 3'b000};
      count_next = c1;
      if (enq) begin
         q_next     = q_next | ({64'd0, word} << {c1, 3'b000});
         count_next = c1 + {1'b0, load_len};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         q_reg      <= '0;
         count_reg  <= '0;
         head_pc    <= '0;
         fetch_addr <= '0;
         offset_reg <= '0;
      end else if (redirect) begin
         q_reg     <= '0;
         count_reg <= '0;
         head_pc   <= redirect_addr;
         if (mem_req && !mem_ack) begin
            state <= DRAIN;
         end else begin
            state      <= RUN;
            fetch_addr <= {redirect_addr[63:3], 3'b000};
            offset_reg <= redirect_addr[2:0];
         end
      end else begin
         case (state)
            DRAIN: begin
               // head_pc already holds the redirect target while the stale word drains.
               if (mem_ack) begin
                  state      <= RUN;
                  fetch_addr <= {head_pc[63:3], 3'b000};
                  offset_reg <= head_pc[2:0];
               end
            end
            RUN, ERR: begin
               q_reg     <= q_next;
               count_reg <= count_next;
               if (take_fire)
                  head_pc <= head_pc + {60'd0, head_len};
               if (ack_fire && (state == RUN)) begin
                  if (mem_err) begin
                     state <= ERR;
                  end else begin
                     fetch_addr <= fetch_addr + 64'd8;
                     offset_reg <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef INSTR_PREFETCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         insn_count   <= '0;
         stall_cycles <= '0;
      end else begin
         if (take_fire)
            insn_count <= insn_count + 64'd1;
         if ((state == RUN) && !ins_valid)
            stall_cycles <= stall_cycles + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed self-checking bench for instr_prefetch; the bench itself plays instruction memory.
module tb_instr_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [63:0] redirect_addr;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_data;
   logic        mem_err;
   logic        ins_valid;
   logic [79:0] ins_bytes;
   logic [3:0]  ins_len;
   logic [63:0] ins_addr;
   logic        ins_err;
   logic        ins_take;
`ifdef INSTR_PREFETCH_STATS_EN
   logic [63:0] insn_count;
   logic [63:0] stall_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] NOPS = 64'h1010_1010_1010_1010;

   always #5 clk = ~clk;

   instr_prefetch dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .mem_err(mem_err), .ins_valid(ins_valid), .ins_bytes(ins_bytes), .ins_len(ins_len),
      .ins_addr(ins_addr), .ins_err(ins_err), .ins_take(ins_take)
`ifdef INSTR_PREFETCH_STATS_EN
      , .insn_count(insn_count), .stall_cycles(stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int got, first, last, words;
      reset = 1'b1; redirect = 1'b0; redirect_addr = '0;
      mem_ack = 1'b0; mem_data = '0; mem_err = 1'b0; ins_take = 1'b0;
      tick(); tick();
      check("rst_mem_req",   80'(mem_req),   80'(0));
      check("rst_mem_addr",  80'(mem_addr),  80'(0));
      check("rst_ins_valid", 80'(ins_valid), 80'(0));
      check("rst_ins_err",   80'(ins_err),   80'(0));
      check("rst_ins_addr",  80'(ins_addr),  80'(0));
      check("rst_ins_len",   80'(ins_len),   80'(0));
      check("rst_ins_bytes", ins_bytes,      80'(0));
      reset = 1'b0;
      tick();
      check("idle_no_req", 80'(mem_req), 80'(0));

      // 10-byte instruction straddling two words
      redirect = 1'b1; redirect_addr = 64'h0;
      tick();
      redirect = 1'b0;
      check("t1_req",   80'(mem_req),  80'(1));
      check("t1_addr0", 80'(mem_addr), 80'(0));
      mem_ack = 1'b1; mem_data = 64'h0000_0000_000A_F230;
      tick();
      mem_ack = 1'b0;
      check("t1_partial_valid", 80'(ins_valid), 80'(0));
      check("t1_addr1", 80'(mem_addr), 80'(8));
      mem_ack = 1'b1; mem_data = 64'h1010_1010_1010_0000;
      tick();
      mem_ack = 1'b0;
      check("t1_valid", 80'(ins_valid), 80'(1));
      check("t1_len",   80'(ins_len),   80'(10));
      check("t1_pc",    80'(ins_addr),  80'(0));
      check("t1_bytes", ins_bytes,      80'h0000_0000_0000_000A_F230);
      check("t1_full_noreq", 80'(mem_req), 80'(0));
      ins_take = 1'b1;
      tick();
      ins_take = 1'b0;
      check("t1_next_pc",  80'(ins_addr),  80'(64'hA));
      check("t1_next_len", 80'(ins_len),   80'(1));
      check("t1_next_byte", ins_bytes,     80'h10);
      check("t1_req2",     80'(mem_req),   80'(1));
      check("t1_addr2",    80'(mem_addr),  80'(64'h10));

      // redirect while request to 0x10 is outstanding -> drain stale word
      redirect = 1'b1; redirect_addr = 64'h40;
      tick();
      redirect = 1'b0;
      check("t2_valid_after_redir", 80'(ins_valid), 80'(0));
      check("t2_drain_req",  80'(mem_req),  80'(1));
      check("t2_drain_addr", 80'(mem_addr), 80'(64'h10));
      mem_ack = 1'b1; mem_data = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      check("t2_discarded", 80'(ins_valid), 80'(0));
      check("t2_new_addr",  80'(mem_addr),  80'(64'h40));
      mem_ack = 1'b1; mem_data = 64'h6120_1010_1010_1010;
      tick();
      mem_ack = 1'b0;
      check("t2_valid", 80'(ins_valid), 80'(1));
      check("t2_pc",    80'(ins_addr),  80'(64'h40));
      check("t2_byte",  ins_bytes,      80'h10);
      check("t2_addr48", 80'(mem_addr), 80'(64'h48));
      mem_ack = 1'b1; mem_data = NOPS;
      tick();
      mem_ack = 1'b0;
      check("t2_full_noreq", 80'(mem_req), 80'(0));

      // unaligned redirect: leading bytes dropped
      redirect = 1'b1; redirect_addr = 64'h13;
      tick();
      redirect = 1'b0;
      check("t3_addr", 80'(mem_addr), 80'(64'h10));
      check("t3_req",  80'(mem_req),  80'(1));
      mem_ack = 1'b1; mem_data = 64'h1010_1033_20CC_BBAA;
      tick();
      mem_ack = 1'b0;
      check("t3_valid", 80'(ins_valid), 80'(1));
      check("t3_pc",    80'(ins_addr),  80'(64'h13));
      check("t3_len",   80'(ins_len),   80'(2));
      check("t3_bytes", ins_bytes,      80'h3320);
      check("t3_addr18", 80'(mem_addr), 80'(64'h18));
      ins_take = 1'b1;
      tick();
      ins_take = 1'b0;
      check("t3_next_pc", 80'(ins_addr), 80'(64'h15));
      mem_ack = 1'b1; mem_data = NOPS;
      tick();
      mem_ack = 1'b0;
      check("t3_noreq", 80'(mem_req), 80'(0));

      // 16 nops with take held: one per cycle
      redirect = 1'b1; redirect_addr = 64'h100; ins_take = 1'b1;
      tick();
      redirect = 1'b0;
      got = 0; first = -1; last = -1; words = 0;
      for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
         if (ins_valid) begin
            check("stream_pc", 80'(ins_addr), 80'(64'h100 + 64'(got)));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         mem_ack = mem_req && (words < 2);
         mem_data = NOPS;
         if (mem_ack) begin
            check("stream_maddr", 80'(mem_addr), 80'(64'h100 + 64'(8 * words)));
            words++;
         end
         tick();
      end
      mem_ack = 1'b0; ins_take = 1'b0;
      check("stream_count", 80'(got), 80'(16));
      check("stream_rate",  80'(last - first), 80'(15));

      // error word after a run of nops; request to 0x110 is still pending
      redirect = 1'b1; redirect_addr = 64'hFF8;
      tick();
      redirect = 1'b0;
      check("t5_drain_addr", 80'(mem_addr), 80'(64'h110));
      mem_ack = 1'b1; mem_data = 64'h0;
      tick();
      check("t5_addr", 80'(mem_addr), 80'(64'hFF8));
      mem_data = NOPS;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t5_pc", 80'(ins_addr), 80'(64'hFF8 + 64'(i)));
         ins_take = 1'b1;
         tick();
      end
      ins_take = 1'b0;
      check("t5_err_addr", 80'(mem_addr), 80'(64'h1000));
      mem_ack = 1'b1; mem_err = 1'b1; mem_data = NOPS;
      tick();
      mem_ack = 1'b0; mem_err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t5_rest_valid", 80'(ins_valid), 80'(1));
         check("t5_rest_err",   80'(ins_err),   80'(0));
         check("t5_rest_pc",    80'(ins_addr),  80'(64'hFFB + 64'(i)));
         ins_take = 1'b1;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         check("t5_err_valid", 80'(ins_valid), 80'(1));
         check("t5_err_flag",  80'(ins_err),   80'(1));
         check("t5_err_pc",    80'(ins_addr),  80'(64'h1000));
         check("t5_err_len",   80'(ins_len),   80'(1));
         check("t5_err_noreq", 80'(mem_req),   80'(0));
         tick();
      end

      // redirect beats take
      redirect = 1'b1; redirect_addr = 64'h200;
      tick();
      redirect = 1'b0; ins_take = 1'b0;
      check("t6_valid", 80'(ins_valid), 80'(0));
      check("t6_err",   80'(ins_err),   80'(0));
      check("t6_req",   80'(mem_req),   80'(1));
      check("t6_addr",  80'(mem_addr),  80'(64'h200));
`ifdef INSTR_PREFETCH_STATS_EN
      check("stats_insn", 80'(insn_count), 80'(26));
`endif

      // asynchronous reset mid-request, then a stray ack
      reset = 1'b1;
      #1;
      check("t7_req",   80'(mem_req),   80'(0));
      check("t7_valid", 80'(ins_valid), 80'(0));
      check("t7_addr",  80'(mem_addr),  80'(0));
      check("t7_pc",    80'(ins_addr),  80'(0));
      tick();
      reset = 1'b0;
      mem_ack = 1'b1; mem_data = NOPS;
      tick();
      mem_ack = 1'b0;
      check("t7_stray_req",   80'(mem_req),   80'(0));
      check("t7_stray_valid", 80'(ins_valid), 80'(0));
      check("t7_stray_len",   80'(ins_len),   80'(0));
`ifdef INSTR_PREFETCH_STATS_EN
      check("stats_cleared", 80'(insn_count), 80'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
